// File: rtl/freq_peak_reader_if.sv
// Streaming FFT-frame sink plus valid/ack peak-result port for freq_peak_reader.
// The master side drives frames and acknowledges results. The slave side is the peak reader.
interface freq_peak_reader_if #(
  parameter int WIDTH  = 20,
  parameter int LENGTH = 2048
);
  localparam int BIN_W = $clog2(LENGTH / 2);

  logic                    sink_sop;
  logic                    sink_eop;
  logic                    sink_valid;
  logic signed [WIDTH-1:0] sink_re;
  logic signed [WIDTH-1:0] sink_im;

  logic                    result_valid;
  logic                    result_ack;
  logic [BIN_W-1:0]        result_bin;
  logic signed [WIDTH-1:0] result_re;
  logic signed [WIDTH-1:0] result_im;
  logic [WIDTH:0]          result_mag;

  modport master (
    output sink_sop, sink_eop, sink_valid, sink_re, sink_im, result_ack,
    input  result_valid, result_bin, result_re, result_im, result_mag
  );

  modport slave (
    input  sink_sop, sink_eop, sink_valid, sink_re, sink_im, result_ack,
    output result_valid, result_bin, result_re, result_im, result_mag
  );
endinterface

// File: rtl/freq_peak_reader.sv
// Consumes one sop/eop-framed FFT frame and reports the largest |re|+|im| bin of the
// positive-frequency half through a held valid/ack result port.
module freq_peak_reader #(
  parameter int WIDTH   = 20,
  parameter int LENGTH  = 2048,
  parameter bit SKIP_DC = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  freq_peak_reader_if.slave     bus,
  output logic                  o_frame_error,
  output logic                  o_overrun
);
  localparam int HALF  = LENGTH / 2;
  localparam int BIN_W = $clog2(HALF);
  localparam int CNT_W = $clog2(LENGTH);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LENGTH - 1);
  localparam logic [CNT_W-1:0] HALF_BEAT = CNT_W'(HALF);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  // The most negative input maps to 2^(WIDTH-1), which still fits unsigned WIDTH bits.
  function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] v);
    if (v[WIDTH-1]) begin
      abs_val = (~v) + WIDTH'(1);
    end else begin
      abs_val = v;
    end
  endfunction

  function automatic logic [WIDTH:0] mag_of(input logic signed [WIDTH-1:0] re,
                                            input logic signed [WIDTH-1:0] im);
    mag_of = {1'b0, abs_val(re)} + {1'b0, abs_val(im)};
  endfunction

  state_t                  r_state;
  state_t                  w_state_next;
  logic [CNT_W-1:0]        r_beat;
  logic [BIN_W-1:0]        r_best_bin;
  logic signed [WIDTH-1:0] r_best_re;
  logic signed [WIDTH-1:0] r_best_im;
  logic [WIDTH:0]          r_best_mag;
  logic                    r_result_valid;
  logic [BIN_W-1:0]        r_result_bin;
  logic signed [WIDTH-1:0] r_result_re;
  logic signed [WIDTH-1:0] r_result_im;
  logic [WIDTH:0]          r_result_mag;
  logic                    r_frame_error;
  logic                    r_overrun;

  logic [WIDTH:0]          w_mag;
  logic                    w_sop_beat;
  logic                    w_start;
  logic                    w_advance;
  logic                    w_update;
  logic                    w_publish;
  logic                    w_clear;
  logic                    w_err;
  logic                    w_ovr;

  assign w_mag      = mag_of(bus.sink_re, bus.sink_im);
  assign w_sop_beat = bus.sink_valid & bus.sink_sop;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A sop beat that is also eop is a one-beat frame, so it is malformed rather than a start.
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_advance    = 1'b0;
    w_update     = 1'b0;
    w_publish    = 1'b0;
    w_clear      = 1'b0;
    w_err        = 1'b0;
    w_ovr        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_sop_beat) begin
          if (bus.sink_eop) begin
            w_err = 1'b1;
          end else begin
            w_start      = 1'b1;
            w_state_next = S_CAPTURE;
          end
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_CAPTURE: begin
        if (!bus.sink_valid) begin
          w_state_next = S_CAPTURE;
        end else if (bus.sink_sop) begin
          w_err = 1'b1;
          if (bus.sink_eop) begin
            w_state_next = S_IDLE;
          end else begin
            w_start      = 1'b1;
            w_state_next = S_CAPTURE;
          end
        end else if (r_beat == LAST_BEAT) begin
          if (bus.sink_eop) begin
            w_publish    = 1'b1;
            w_state_next = S_HOLD;
          end else begin
            w_err        = 1'b1;
            w_state_next = S_IDLE;
          end
        end else if (bus.sink_eop) begin
          w_err        = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          w_advance = 1'b1;
          w_update  = (r_beat < HALF_BEAT) && (w_mag > r_best_mag);
        end
      end
      S_HOLD: begin
        if (bus.result_ack) begin
          w_clear = 1'b1;
          if (w_sop_beat && !bus.sink_eop) begin
            w_start      = 1'b1;
            w_state_next = S_CAPTURE;
          end else begin
            w_err        = w_sop_beat;
            w_state_next = S_IDLE;
          end
        end else if (w_sop_beat) begin
          w_ovr = 1'b1;
        end else begin
          w_state_next = S_HOLD;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Beat counter rests at zero whenever no frame is being captured.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_beat <= {CNT_W{1'b0}};
    end else if (w_start) begin
      r_beat <= CNT_W'(1);
    end else if (w_advance) begin
      r_beat <= r_beat + CNT_W'(1);
    end else if (w_state_next != S_CAPTURE) begin
      r_beat <= {CNT_W{1'b0}};
    end else begin
      r_beat <= r_beat;
    end
  end

  // Strictly-greater update keeps the lowest bin on ties.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_best_bin <= {BIN_W{1'b0}};
      r_best_re  <= {WIDTH{1'b0}};
      r_best_im  <= {WIDTH{1'b0}};
      r_best_mag <= {(WIDTH+1){1'b0}};
    end else if (w_start) begin
      r_best_bin <= {BIN_W{1'b0}};
      if (SKIP_DC) begin
        r_best_re  <= {WIDTH{1'b0}};
        r_best_im  <= {WIDTH{1'b0}};
        r_best_mag <= {(WIDTH+1){1'b0}};
      end else begin
        r_best_re  <= bus.sink_re;
        r_best_im  <= bus.sink_im;
        r_best_mag <= w_mag;
      end
    end else if (w_update) begin
      r_best_bin <= r_beat[BIN_W-1:0];
      r_best_re  <= bus.sink_re;
      r_best_im  <= bus.sink_im;
      r_best_mag <= w_mag;
    end else begin
      r_best_bin <= r_best_bin;
      r_best_re  <= r_best_re;
      r_best_im  <= r_best_im;
      r_best_mag <= r_best_mag;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_result_valid <= 1'b0;
      r_result_bin   <= {BIN_W{1'b0}};
      r_result_re    <= {WIDTH{1'b0}};
      r_result_im    <= {WIDTH{1'b0}};
      r_result_mag   <= {(WIDTH+1){1'b0}};
    end else if (w_publish) begin
      r_result_valid <= 1'b1;
      r_result_bin   <= r_best_bin;
      r_result_re    <= r_best_re;
      r_result_im    <= r_best_im;
      r_result_mag   <= r_best_mag;
    end else if (w_clear) begin
      r_result_valid <= 1'b0;
    end else begin
      r_result_valid <= r_result_valid;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_frame_error <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_frame_error <= w_err;
      r_overrun     <= w_ovr;
    end
  end

  assign bus.result_valid = r_result_valid;
  assign bus.result_bin   = r_result_bin;
  assign bus.result_re    = r_result_re;
  assign bus.result_im    = r_result_im;
  assign bus.result_mag   = r_result_mag;
  assign o_frame_error    = r_frame_error;
  assign o_overrun        = r_overrun;
endmodule

// File: tb/tb_freq_peak_reader.sv
// Scoreboard bench: two readers (SKIP_DC=1 and SKIP_DC=0) see the same frames; a
// reference model queues the expected peak per frame and a monitor pops on each new result.
module tb_freq_peak_reader;
  localparam int W = 8;
  localparam int L = 16;
  localparam int H = L / 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic tb_sop = 1'b0, tb_eop = 1'b0, tb_valid = 1'b0, tb_ack = 1'b0;
  logic signed [W-1:0] tb_re = '0, tb_im = '0;
  logic ferr_s, ovr_s, ferr_d, ovr_d;

  freq_peak_reader_if #(.WIDTH(W), .LENGTH(L)) ifs ();
  freq_peak_reader_if #(.WIDTH(W), .LENGTH(L)) ifd ();

  assign ifs.sink_sop = tb_sop;   assign ifd.sink_sop = tb_sop;
  assign ifs.sink_eop = tb_eop;   assign ifd.sink_eop = tb_eop;
  assign ifs.sink_valid = tb_valid; assign ifd.sink_valid = tb_valid;
  assign ifs.sink_re = tb_re;     assign ifd.sink_re = tb_re;
  assign ifs.sink_im = tb_im;     assign ifd.sink_im = tb_im;
  assign ifs.result_ack = tb_ack; assign ifd.result_ack = tb_ack;

  freq_peak_reader #(.WIDTH(W), .LENGTH(L), .SKIP_DC(1'b1)) dut_skip (
    .i_clk(clk), .i_reset(reset), .bus(ifs), .o_frame_error(ferr_s), .o_overrun(ovr_s));
  freq_peak_reader #(.WIDTH(W), .LENGTH(L), .SKIP_DC(1'b0)) dut_dc (
    .i_clk(clk), .i_reset(reset), .bus(ifd), .o_frame_error(ferr_d), .o_overrun(ovr_d));

  typedef struct { int bin; int re; int im; int mag; } exp_t;
  exp_t q_s[$];
  exp_t q_d[$];
  exp_t cur_s, cur_d;
  logic pv_s = 1'b0, pv_d = 1'b0;
  int fre[L];
  int fim[L];
  int n_cmp = 0, n_bad = 0;
  int ferr_s_cnt = 0, ovr_s_cnt = 0, ferr_d_cnt = 0, ovr_d_cnt = 0;
  int exp_ferr = 0, exp_ovr = 0;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic exp_t model(input bit skip);
    exp_t b;
    b.bin = 0;
    b.re  = skip ? 0 : fre[0];
    b.im  = skip ? 0 : fim[0];
    b.mag = skip ? 0 : iabs(fre[0]) + iabs(fim[0]);
    for (int i = 1; i < H; i++) begin
      if (iabs(fre[i]) + iabs(fim[i]) > b.mag) begin
        b.bin = i; b.re = fre[i]; b.im = fim[i]; b.mag = iabs(fre[i]) + iabs(fim[i]);
      end
    end
    return b;
  endfunction

  task automatic push_expected();
    q_s.push_back(model(1'b1));
    q_d.push_back(model(1'b0));
  endtask

  task automatic fill_base();
    for (int i = 0; i < L; i++) begin
      fre[i] = 1; fim[i] = 1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic beat(input bit sop, input bit eop, input int re, input int im);
    tb_valid = 1'b1; tb_sop = sop; tb_eop = eop;
    tb_re = re[W-1:0]; tb_im = im[W-1:0];
    @(posedge clk); #1;
    tb_valid = 1'b0; tb_sop = 1'b0; tb_eop = 1'b0; tb_ack = 1'b0;
  endtask

  task automatic send_frame(input int first, input int last, input int eop_at,
                            input int gap_at, input int gap_len, input bit ack_first);
    for (int i = first; i <= last; i++) begin
      if (i == gap_at) idle(gap_len);
      if (ack_first && i == first) tb_ack = 1'b1;
      beat(i == 0, i == eop_at, fre[i], fim[i]);
    end
  endtask

  task automatic do_ack();
    idle(2);
    tb_ack = 1'b1;
    idle(1);
    tb_ack = 1'b0;
    chk("ack_drop_s", ifs.result_valid, 0);
    chk("ack_drop_d", ifd.result_valid, 0);
  endtask

  task automatic good_frame(input string tag, input int gap_at, input int gap_len);
    push_expected();
    send_frame(0, L - 1, L - 1, gap_at, gap_len, 1'b0);
    chk({tag, "_lat_s"}, ifs.result_valid, 1);
    chk({tag, "_lat_d"}, ifd.result_valid, 1);
    do_ack();
  endtask

  // New result pops the scoreboard; a held result must not move.
  always @(negedge clk) begin
    if (ifs.result_valid && !pv_s) begin
      if (q_s.size() == 0) chk("skip_unexpected", q_s.size(), 1);
      else begin
        cur_s = q_s.pop_front();
        chk("skip_bin", ifs.result_bin, cur_s.bin); chk("skip_re", ifs.result_re, cur_s.re);
        chk("skip_im", ifs.result_im, cur_s.im);    chk("skip_mag", ifs.result_mag, cur_s.mag);
      end
    end else if (ifs.result_valid) begin
      chk("skip_hold_bin", ifs.result_bin, cur_s.bin); chk("skip_hold_mag", ifs.result_mag, cur_s.mag);
      chk("skip_hold_re", ifs.result_re, cur_s.re);    chk("skip_hold_im", ifs.result_im, cur_s.im);
    end
    if (ifd.result_valid && !pv_d) begin
      if (q_d.size() == 0) chk("dc_unexpected", q_d.size(), 1);
      else begin
        cur_d = q_d.pop_front();
        chk("dc_bin", ifd.result_bin, cur_d.bin); chk("dc_re", ifd.result_re, cur_d.re);
        chk("dc_im", ifd.result_im, cur_d.im);    chk("dc_mag", ifd.result_mag, cur_d.mag);
      end
    end
    pv_s = ifs.result_valid;
    pv_d = ifd.result_valid;
    ferr_s_cnt += int'(ferr_s); ovr_s_cnt += int'(ovr_s);
    ferr_d_cnt += int'(ferr_d); ovr_d_cnt += int'(ovr_d);
  end

  initial begin
    reset = 1'b1;
    idle(3);
    chk("rst_valid", ifs.result_valid, 0); chk("rst_bin", ifs.result_bin, 0);
    chk("rst_re", ifs.result_re, 0);       chk("rst_im", ifs.result_im, 0);
    chk("rst_mag", ifs.result_mag, 0);     chk("rst_ferr", ferr_s, 0);
    chk("rst_ovr", ovr_s, 0);              chk("rst_valid_d", ifd.result_valid, 0);
    reset = 1'b0;
    idle(1);
    tb_ack = 1'b1; idle(1); tb_ack = 1'b0;
    chk("ack_idle", ifs.result_valid, 0);

    fill_base(); fre[0] = 100; fim[0] = 0; fre[3] = 40; fim[3] = -30;
    good_frame("peak3", -1, 0);

    fill_base(); fre[0] = 100; fim[0] = 0; fre[2] = -128; fim[2] = 0; fre[5] = -128; fim[5] = 0;
    good_frame("tie", -1, 0);

    fill_base(); fre[0] = 127; fim[0] = 127;
    good_frame("dcbig", -1, 0);

    fill_base(); fre[0] = 0; fim[0] = 0; fre[12] = 127; fim[12] = 127; fre[6] = 5; fim[6] = -5;
    good_frame("gap", $urandom_range(1, L - 1), $urandom_range(1, 5));
    good_frame("nogap", -1, 0);

    send_frame(0, 9, 9, -1, 0, 1'b0);
    exp_ferr++;
    chk("eop9_ferr", ferr_s, 1);
    idle(1);
    chk("eop9_ferr_one", ferr_s, 0);
    chk("eop9_valid", ifs.result_valid, 0);
    fill_base(); fre[0] = 100; fim[0] = 0; fre[3] = 40; fim[3] = -30;
    good_frame("after_err", -1, 0);

    send_frame(0, L - 1, -1, -1, 0, 1'b0);
    exp_ferr++;
    chk("noeop_ferr", ferr_s, 1);
    idle(1);
    chk("noeop_valid", ifs.result_valid, 0);

    send_frame(0, 4, -1, -1, 0, 1'b0);
    exp_ferr++;
    good_frame("restart", -1, 0);

    push_expected();
    send_frame(0, L - 1, L - 1, -1, 0, 1'b0);
    fill_base(); fre[4] = 90; fim[4] = 90;
    send_frame(0, L - 1, L - 1, -1, 0, 1'b0);
    exp_ovr++;
    idle(2);
    chk("ovr_hold_valid", ifs.result_valid, 1);
    chk("ovr_hold_bin", ifs.result_bin, 3);
    fill_base(); fre[7] = -60; fim[7] = 20;
    push_expected();
    send_frame(0, L - 1, L - 1, -1, 0, 1'b1);
    chk("ackstart_lat", ifs.result_valid, 1);
    do_ack();

    fill_base(); fre[0] = 100; fim[0] = 0; fre[3] = 40; fim[3] = -30;
    send_frame(0, 6, -1, -1, 0, 1'b0);
    reset = 1'b1;
    beat(1'b0, 1'b0, fre[7], fim[7]);
    chk("mrst_valid", ifs.result_valid, 0); chk("mrst_bin", ifs.result_bin, 0);
    chk("mrst_re", ifs.result_re, 0);       chk("mrst_im", ifs.result_im, 0);
    chk("mrst_mag", ifs.result_mag, 0);
    reset = 1'b0;
    send_frame(8, L - 1, L - 1, -1, 0, 1'b0);
    idle(2);
    chk("mrst_tail_valid", ifs.result_valid, 0);
    good_frame("after_rst", -1, 0);

    idle(3);
    chk("ferr_count_s", ferr_s_cnt, exp_ferr);
    chk("ovr_count_s", ovr_s_cnt, exp_ovr);
    chk("ferr_count_d", ferr_d_cnt, exp_ferr);
    chk("ovr_count_d", ovr_d_cnt, exp_ovr);
    chk("sb_left_s", q_s.size(), 0);
    chk("sb_left_d", q_d.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
